commit_unit: RTL and testbench
==============================

// Module: commit_unit
// PURPOSE
//  In-order retirement stage of the OoO MIPS core; sits upstream of the per-cycle state-update register block.
//  - Inspects the oldest active-list entry and retires at most one instruction per cycle.
//  - Drives the commit pointers, plus the branch_done/load_done/store_done strobes that free branch/LQ/SQ slots.
//  - Returns the reclaimed physical register to the free-list tail.
//  - Sequences committed stores into the D-cache through a request/ack handshake.
// PARAMETERS
//  AL_DEPTH    64  active-list entries (power of 2)
//  FREE_DEPTH  32  free-list entries (power of 2)
//  LQ_DEPTH    16  load-queue entries (power of 2)
//  SQ_DEPTH    16  store-queue entries (power of 2)
//  BR_DEPTH     8  branch-stack entries (power of 2)
//  PREG_W       6  physical register index width
// PORTS
//  clk               in   1            clock; all state updates on posedge
//  rst               in   1            synchronous, active-high reset
//  head_valid        in   1            active-list entry at oldest_inst_pointer is occupied
//  head_ready        in   1            that entry has completed execution
//  head_is_load      in   1            head entry is a load
//  head_is_store     in   1            head entry is a store
//  head_is_branch    in   1            head entry is a branch
//  head_uses_rw      in   1            head entry writes a register; reclaim field is valid
//  head_reclaim      in   PREG_W       previous physical mapping of head's destination
//  branch_miss       in   1            misprediction flush this cycle
//  store_ack         in   1            D-cache accepted and completed the committed store
//  commit_valid      out  1            one instruction retires this cycle
//  oldest_inst_pointer  out clog2(AL_DEPTH)  active-list head index
//  free_tail_pointer    out clog2(FREE_DEPTH) free-list write index
//  free_wr_en        out  1            write reclaim_reg to free list at free_tail_pointer
//  reclaim_reg       out  PREG_W       register being freed
//  load_commit_pointer  out clog2(LQ_DEPTH)
//  store_commit_pointer out clog2(SQ_DEPTH)
//  branch_read_pointer  out clog2(BR_DEPTH)
//  load_done / store_done / branch_done  out 1 each  single-cycle slot-release strobes
//  store_req         out  1            request D-cache write of SQ[store_commit_pointer]
// BEHAVIOUR
//  Reset:
//  - All pointers 0; FSM = RUN.
//  - All strobes, store_req, free_wr_en and commit_valid 0; reclaim_reg 0.
//  FSM RUN:
//  - Retire = head_valid & head_ready & !branch_miss & !head_is_store.
//  - On retire, all in the same cycle (combinational outputs):
//    - commit_valid=1.
//    - free_wr_en=head_uses_rw; reclaim_reg=head_reclaim.
//    - load_done=head_is_load; branch_done=head_is_branch.
//  - Pointer updates at the next edge:
//    - oldest_inst_pointer+1.
//    - free_tail_pointer+1 if uses_rw.
//    - load_commit_pointer+1 if load; branch_read_pointer+1 if branch.
//  - Ready store at head (head_valid & head_ready & head_is_store & !branch_miss): go to ST_WAIT; no retire this cycle.
//  FSM ST_WAIT:
//  - store_req=1 every cycle until store_ack.
//  - On store_ack, same cycle: commit_valid=1, store_done=1, free_wr_en=head_uses_rw (normally 0).
//  - At the next edge: store_commit_pointer+1, oldest_inst_pointer+1, return to RUN.
//  - branch_miss is ignored in ST_WAIT: the store is older than any in-flight branch.
//  Timing and ordering rules:
//  - Retire latency: 0 cycles from head_ready for non-stores; ≥1 cycle for stores.
//  - Max one retire per cycle.
//  - All pointers wrap modulo their depth (natural power-of-2 overflow).
//  - Empty (head_valid=0): no strobes, pointers hold.
//  - branch_miss in RUN: suppress retire for that cycle only; the head is older than the branch so it is valid next cycle.
//  - rst mid-ST_WAIT: abandon the store, drop store_req the next cycle, restore the reset state.
//  - At most one of load_done/store_done/branch_done is high in any cycle.
// TESTING
//  - Reset: rst=1 two cycles -> every pointer and strobe 0, FSM RUN, store_req=0.
//  - ALU retire: head ready, uses_rw=1, reclaim=6'd37 -> same cycle free_wr_en=1, reclaim_reg=37; next cycle oldest=1, free_tail=1.
//  - Wrap: 64 back-to-back ready loads -> oldest_inst_pointer 63->0; load_commit_pointer wraps four times to 0.
//  - Store handshake: store ready, store_ack after 3 cycles -> store_req high 3 cycles, store_done one pulse, store_commit_pointer 0->1.
//  - Flush: branch head ready with branch_miss=1 -> no branch_done that cycle; next cycle branch_done=1 and branch_read_pointer 0->1.
//  - Reset in ST_WAIT: rst while store_req=1 -> next cycle store_req=0, oldest_inst_pointer=0, no store_done.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit
// In-order retirement stage of the out-of-order core. Looks at the oldest
// active-list entry and retires at most one instruction per cycle. When an
// instruction retires it:
//   - frees the previous physical register mapping into the free list,
//   - releases its load-queue, store-queue or branch-stack slot,
//   - advances the active-list head pointer.
// Stores do not retire immediately. Each store is first written to the
// D-cache through a request/acknowledge handshake.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   head_*                    status of the active-list entry at oldest_inst_pointer
//   branch_miss               misprediction flush this cycle
//   store_ack                 D-cache completed the committed store
//   commit_valid              one instruction retires this cycle
//   oldest_inst_pointer       active-list head index
//   free_tail_pointer         free-list write index
//   free_wr_en, reclaim_reg   free-list write strobe and data
//   load_commit_pointer       load-queue commit index
//   store_commit_pointer      store-queue commit index
//   branch_read_pointer       branch-stack read index
//   load_done/store_done/branch_done  single-cycle slot-release strobes
//   store_req                 D-cache write request for SQ[store_commit_pointer]
//   fsm_state                 debug view of the retirement FSM (0 = RUN, 1 = ST_WAIT)
//
// Store handshake: store_req is held high in every ST_WAIT cycle. The cycle in
// which store_ack is sampled high, while store_req is high, completes the
// transfer. The store retires in that same cycle. store_ack is ignored
// whenever store_req is low.

module commit_unit #(
    parameter int AL_DEPTH   = 64,
    parameter int FREE_DEPTH = 32,
    parameter int LQ_DEPTH   = 16,
    parameter int SQ_DEPTH   = 16,
    parameter int BR_DEPTH   = 8,
    parameter int PREG_W     = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          head_valid,
    input  logic                          head_ready,
    input  logic                          head_is_load,
    input  logic                          head_is_store,
    input  logic                          head_is_branch,
    input  logic                          head_uses_rw,
    input  logic [PREG_W-1:0]             head_reclaim,
    input  logic                          branch_miss,
    input  logic                          store_ack,
    output logic                          commit_valid,
    output logic [$clog2(AL_DEPTH)-1:0]   oldest_inst_pointer,
    output logic [$clog2(FREE_DEPTH)-1:0] free_tail_pointer,
    output logic                          free_wr_en,
    output logic [PREG_W-1:0]             reclaim_reg,
    output logic [$clog2(LQ_DEPTH)-1:0]   load_commit_pointer,
    output logic [$clog2(SQ_DEPTH)-1:0]   store_commit_pointer,
    output logic [$clog2(BR_DEPTH)-1:0]   branch_read_pointer,
    output logic                          load_done,
    output logic                          store_done,
    output logic                          branch_done,
    output logic                          store_req,
    output logic                          fsm_state
);

    localparam int AL_W = $clog2(AL_DEPTH);
    localparam int FL_W = $clog2(FREE_DEPTH);
    localparam int LQ_W = $clog2(LQ_DEPTH);
    localparam int SQ_W = $clog2(SQ_DEPTH);
    localparam int BR_W = $clog2(BR_DEPTH);

    localparam logic [AL_W-1:0] AL_ONE = 1;
    localparam logic [FL_W-1:0] FL_ONE = 1;
    localparam logic [LQ_W-1:0] LQ_ONE = 1;
    localparam logic [SQ_W-1:0] SQ_ONE = 1;
    localparam logic [BR_W-1:0] BR_ONE = 1;

    typedef enum logic {
        RUN     = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Head entry has finished execution and may leave the window.
    logic head_done;
    assign head_done = head_valid & head_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and retirement strobes
    // ------------------------------------------------------------------
    // Every output is qualified with !rst, so nothing retires and no
    // D-cache request is made while reset is held. A store that is
    // waiting when reset arrives is therefore dropped cleanly.
    always_comb begin
        state_d      = state_q;
        commit_valid = 1'b0;
        free_wr_en   = 1'b0;
        load_done    = 1'b0;
        store_done   = 1'b0;
        branch_done  = 1'b0;
        store_req    = 1'b0;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    // The head is always older than a mispredicted branch.
                    // A flush only delays retirement by one cycle and never
                    // removes the head entry.
                    if (head_done && !branch_miss) begin
                        if (head_is_store) begin
                            state_d = ST_WAIT;
                        end else begin
                            commit_valid = 1'b1;
                            free_wr_en   = head_uses_rw;
                            load_done    = head_is_load;
                            branch_done  = head_is_branch;
                        end
                    end
                end

                ST_WAIT: begin
                    // branch_miss is not looked at here. The store is older
                    // than every in-flight branch, so a flush cannot cancel it.
                    store_req = 1'b1;
                    if (store_ack) begin
                        commit_valid = 1'b1;
                        store_done   = 1'b1;
                        free_wr_en   = head_uses_rw;
                        state_d      = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // The reclaim bus reads as zero unless the free list is being written.
    assign reclaim_reg = free_wr_en ? head_reclaim : '0;
    assign fsm_state   = state_q;

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    // Each pointer advances on the strobe that releases its slot.
    // Power-of-2 depths make the natural overflow act as the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            oldest_inst_pointer  <= '0;
            free_tail_pointer    <= '0;
            load_commit_pointer  <= '0;
            store_commit_pointer <= '0;
            branch_read_pointer  <= '0;
        end else begin
            if (commit_valid) begin
                oldest_inst_pointer <= oldest_inst_pointer + AL_ONE;
            end
            if (free_wr_en) begin
                free_tail_pointer <= free_tail_pointer + FL_ONE;
            end
            if (load_done) begin
                load_commit_pointer <= load_commit_pointer + LQ_ONE;
            end
            if (store_done) begin
                store_commit_pointer <= store_commit_pointer + SQ_ONE;
            end
            if (branch_done) begin
                branch_read_pointer <= branch_read_pointer + BR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;

  // ------------------------------------------------------------------
  // clock / reset and DUT
  // ------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       head_valid, head_ready, head_is_load, head_is_store;
  logic       head_is_branch, head_uses_rw;
  logic [5:0] head_reclaim;
  logic       branch_miss, store_ack;
  logic       commit_valid, free_wr_en;
  logic [5:0] oldest_inst_pointer;
  logic [4:0] free_tail_pointer;
  logic [5:0] reclaim_reg;
  logic [3:0] load_commit_pointer, store_commit_pointer;
  logic [2:0] branch_read_pointer;
  logic       load_done, store_done, branch_done, store_req, fsm_state;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_ready(head_ready),
    .head_is_load(head_is_load), .head_is_store(head_is_store),
    .head_is_branch(head_is_branch), .head_uses_rw(head_uses_rw),
    .head_reclaim(head_reclaim), .branch_miss(branch_miss),
    .store_ack(store_ack), .commit_valid(commit_valid),
    .oldest_inst_pointer(oldest_inst_pointer),
    .free_tail_pointer(free_tail_pointer), .free_wr_en(free_wr_en),
    .reclaim_reg(reclaim_reg), .load_commit_pointer(load_commit_pointer),
    .store_commit_pointer(store_commit_pointer),
    .branch_read_pointer(branch_read_pointer),
    .load_done(load_done), .store_done(store_done),
    .branch_done(branch_done), .store_req(store_req), .fsm_state(fsm_state)
  );

  // ------------------------------------------------------------------
  // reference model: retirement counts, pointers are count mod depth
  // ------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int n_ret, n_free, n_ld, n_st, n_br;
  bit waiting;
  int req_cycles, sdone_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are set before the call (about 1ns after a rising edge). The
  // combinational outputs are checked mid-cycle. The pointers are checked
  // after the next edge.
  task automatic step();
    bit e_cv, e_fwe, e_ld, e_st, e_br, e_req, go_wait;
    logic [5:0] e_rr;
    e_cv = 0; e_fwe = 0; e_ld = 0; e_st = 0; e_br = 0; e_req = 0; go_wait = 0;
    if (!rst) begin
      if (!waiting) begin
        if (head_valid && head_ready && !branch_miss) begin
          if (head_is_store) go_wait = 1;
          else begin
            e_cv = 1; e_fwe = head_uses_rw;
            e_ld = head_is_load; e_br = head_is_branch;
          end
        end
      end else begin
        e_req = 1;
        if (store_ack) begin
          e_cv = 1; e_st = 1; e_fwe = head_uses_rw;
        end
      end
    end
    e_rr = e_fwe ? head_reclaim : 6'd0;
    #3;
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    chk("free_wr_en", 32'(free_wr_en), 32'(e_fwe));
    chk("reclaim_reg", 32'(reclaim_reg), 32'(e_rr));
    chk("load_done", 32'(load_done), 32'(e_ld));
    chk("store_done", 32'(store_done), 32'(e_st));
    chk("branch_done", 32'(branch_done), 32'(e_br));
    chk("store_req", 32'(store_req), 32'(e_req));
    if (store_req === 1'b1) req_cycles++;
    if (store_done === 1'b1) sdone_pulses++;
    if (rst) begin
      n_ret = 0; n_free = 0; n_ld = 0; n_st = 0; n_br = 0; waiting = 0;
    end else begin
      if (e_cv) n_ret++;
      if (e_fwe) n_free++;
      if (e_ld) n_ld++;
      if (e_br) n_br++;
      if (e_st) begin n_st++; waiting = 0; end
      if (go_wait) waiting = 1;
    end
    @(posedge clk); #1;
    chk("oldest_ptr", 32'(oldest_inst_pointer), 32'(n_ret % 64));
    chk("free_tail_ptr", 32'(free_tail_pointer), 32'(n_free % 32));
    chk("load_ptr", 32'(load_commit_pointer), 32'(n_ld % 16));
    chk("store_ptr", 32'(store_commit_pointer), 32'(n_st % 16));
    chk("branch_ptr", 32'(branch_read_pointer), 32'(n_br % 8));
    chk("fsm_state", 32'(fsm_state), 32'(waiting));
  endtask

  // driver helpers
  task automatic idle();
    head_valid = 0; head_ready = 0; head_is_load = 0; head_is_store = 0;
    head_is_branch = 0; head_uses_rw = 0; head_reclaim = 0;
    branch_miss = 0; store_ack = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 branch
  task automatic head(input int kind, input bit uses, input logic [5:0] rc);
    head_valid = 1; head_ready = 1;
    head_is_load = (kind == 1); head_is_store = (kind == 2);
    head_is_branch = (kind == 3); head_uses_rw = uses; head_reclaim = rc;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); step(); rst = 0;
  endtask

  // ------------------------------------------------------------------
  // directed steps followed by randomized traffic
  // ------------------------------------------------------------------
  initial begin
    idle(); rst = 1;
    n_ret = 0; n_free = 0; n_ld = 0; n_st = 0; n_br = 0; waiting = 0;
    req_cycles = 0; sdone_pulses = 0;
    @(posedge clk); #1;

    // reset
    do_reset();
    chk("reset_oldest", 32'(oldest_inst_pointer), 32'd0);
    chk("reset_fsm", 32'(fsm_state), 32'd0);

    // ALU retire that frees p37
    head(0, 1, 6'd37); step();
    chk("alu_oldest", 32'(oldest_inst_pointer), 32'd1);
    chk("alu_free_tail", 32'(free_tail_pointer), 32'd1);
    idle(); step();

    // 64 back-to-back loads: head wraps once, load queue four times
    do_reset();
    for (int i = 0; i < 64; i++) begin head(1, 1, 6'(i)); step(); end
    chk("wrap_oldest", 32'(oldest_inst_pointer), 32'd0);
    chk("wrap_load_ptr", 32'(load_commit_pointer), 32'd0);
    chk("wrap_free_tail", 32'(free_tail_pointer), 32'd0);

    // store with the ack arriving in the third request cycle
    do_reset(); req_cycles = 0; sdone_pulses = 0;
    head(2, 0, 6'd0); step();
    step(); step();
    store_ack = 1; step();
    idle(); step();
    chk("st_req_cycles", 32'(req_cycles), 32'd3);
    chk("st_done_pulses", 32'(sdone_pulses), 32'd1);
    chk("st_ptr", 32'(store_commit_pointer), 32'd1);
    chk("st_oldest", 32'(oldest_inst_pointer), 32'd1);

    // branch at the head during a flush retires one cycle later
    do_reset();
    head(3, 0, 6'd0); branch_miss = 1; step();
    chk("flush_br_ptr_hold", 32'(branch_read_pointer), 32'd0);
    branch_miss = 0; step();
    chk("flush_br_ptr", 32'(branch_read_pointer), 32'd1);

    // reset while waiting on the D-cache
    do_reset(); sdone_pulses = 0;
    head(2, 0, 6'd0); step(); step();
    chk("rw_req_before", 32'(store_req), 32'd1);
    idle(); rst = 1; step(); rst = 0;
    step();
    chk("rw_oldest", 32'(oldest_inst_pointer), 32'd0);
    chk("rw_no_sdone", 32'(sdone_pulses), 32'd0);

    // randomized traffic with rare resets
    for (int i = 0; i < 1500; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      rst = ($urandom_range(0, 199) == 0);
      head_valid = ($urandom_range(0, 4) != 0);
      head_ready = ($urandom_range(0, 3) != 0);
      head_is_load = (kind == 1); head_is_store = (kind == 2);
      head_is_branch = (kind == 3);
      head_uses_rw = (kind != 2) && ($urandom_range(0, 3) != 0);
      head_reclaim = 6'($urandom);
      branch_miss = ($urandom_range(0, 5) == 0);
      store_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 0; idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
